pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the IF/ID pipeline register and PC: drives IF/ID load-enable (LE) and
//  flush (R), PC load/select, and ID/EX bubble insert. Resolves load-use stalls,
//  taken-branch flushes and data-memory wait freezes with a registered FSM and
//  Mealy outputs. Sits beside the ID stage; consumes IF/ID register fields and EX/MEM status.
// PARAMETERS
//  LU_STALL     1    load-use stall cycles (>=1)
//  BR_BUBBLES   1    wrong-path flush cycles after taken branch (>=1)
//  MEM_TIMEOUT  255  consecutive mem_busy cycles before mem_timeout sets
//  CNT_W        16   perf counter width
// PORTS
//  clk             in   1      clock, rising edge
//  reset_n         in   1      async active-low reset
//  mem_busy        in   1      data memory not ready; whole pipe must freeze
//  ex_load         in   1      EX-stage instruction is a load
//  ex_rd           in   4      EX-stage destination register
//  id_rn/id_rm/id_rd in 4 each ID source regs (Rd used as store source)
//  id_rn_use/id_rm_use/id_rd_use in 1 each  source actually read
//  id_branch_taken in   1      ID resolved branch taken
//  pc_le           out  1      PC load enable
//  pc_sel_target   out  1      1 = PC loads branch target, 0 = PC+4
//  ifid_le         out  1      IF/ID load enable (LE)
//  ifid_r          out  1      IF/ID flush (R), clears instruction to 0
//  idex_nop        out  1      force ID/EX control to NOP
//  mem_timeout     out  1      sticky watchdog flag
//  state_o         out  2      FSM state (RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3)
//  stall_cnt/flush_cnt out CNT_W  perf counters
// BEHAVIOUR
//  - reset_n=0 (async): state=RUN, counters/mem_timeout=0; outputs forced pc_le=0,
//    ifid_le=0, ifid_r=1, idex_nop=1, pc_sel_target=0. Release: RUN outputs next cycle.
//  - lu = ex_load & ((id_rn_use&id_rn==ex_rd)|(id_rm_use&id_rm==ex_rd)|(id_rd_use&id_rd==ex_rd)).
//  - Priority every state: mem_busy > lu > id_branch_taken.
//  - Any state, mem_busy=1: pc_le=ifid_le=0, ifid_r=idex_nop=0 (freeze); state and
//    remaining-count hold; from RUN go MEM_WAIT. Watchdog counts consecutive busy
//    cycles, clears on busy=0; at MEM_TIMEOUT sets mem_timeout (sticky until reset).
//  - RUN, no event: pc_le=ifid_le=1, others 0.
//  - RUN, lu: pc_le=ifid_le=0, idex_nop=1; rem=LU_STALL-1; go LU_STALL if rem>0 else stay.
//  - LU_STALL: same outputs as lu; rem-- each cycle; rem==1 -> RUN next cycle.
//  - RUN, taken: pc_le=1, pc_sel_target=1, ifid_r=1, ifid_le=1; rem=BR_BUBBLES-1;
//    go FLUSH if rem>0. FLUSH: pc_le=1, sel=0, ifid_r=1, idex_nop=1; rem-- to RUN.
//    id_branch_taken ignored in FLUSH/LU_STALL.
//  - MEM_WAIT, mem_busy=0: RUN output evaluation this cycle, next state per RUN rules.
//  - ifid_r and ifid_le both 1: flush wins (IF/ID gets zero instruction).
//  - Counters saturate at all-ones; never wrap.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: stall_cnt +1 per cycle with pc_le=0 (reset excluded),
//  flush_cnt +1 per cycle ifid_r=1 (reset excluded). Undefined: both ports tied 0,
//  no counter flops.
// TESTING
//  1 Reset held 3 cycles -> ifid_r=1,idex_nop=1,pc_le=0; release -> pc_le=ifid_le=1, state 0.
//  2 ex_load=1,ex_rd=4,id_rm=4,id_rm_use=1 with LU_STALL=2 -> 2 cycles pc_le=0,
//    idex_nop=1, then RUN; stall_cnt=2 if HAZ_PERF_CNT_EN.
//  3 id_branch_taken=1, BR_BUBBLES=2 -> cycle0 sel=1,ifid_r=1; cycle1 ifid_r=1,
//    sel=0; cycle2 RUN; flush_cnt=2.
//  4 lu and branch same cycle -> stall only; branch retaken after stall resolves.
//  5 mem_busy=1 for 255 cycles mid-FLUSH -> outputs frozen, rem preserved,
//    mem_timeout=1 at cycle 255, stays 1 after busy drops; FLUSH finishes.
//  6 reset_n pulsed low inside LU_STALL -> immediate reset outputs, state 0, counts 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the signals between the ID-stage hazard controller and the pipeline
// datapath around it.
//   Hazard status into the controller:
//     mem_busy         data memory not ready; the whole pipe must freeze
//     ex_load, ex_rd   EX-stage instruction is a load, and its destination
//     id_rn/rm/rd      ID-stage source registers (rd is the store source)
//     id_*_use         the matching source is actually read
//     id_branch_taken  the branch in ID resolved taken
//   Pipeline control out of the controller:
//     pc_le            PC load enable
//     pc_sel_target    1 = PC loads branch target, 0 = PC+4
//     ifid_le          IF/ID load enable
//     ifid_r           IF/ID flush (the register loads a zero instruction)
//     idex_nop         force ID/EX control to a NOP
// Modports: master = pipeline side, slave = hazard controller.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic       mem_busy;
  logic       ex_load;
  logic [3:0] ex_rd;
  logic [3:0] id_rn;
  logic [3:0] id_rm;
  logic [3:0] id_rd;
  logic       id_rn_use;
  logic       id_rm_use;
  logic       id_rd_use;
  logic       id_branch_taken;
  logic       pc_le;
  logic       pc_sel_target;
  logic       ifid_le;
  logic       ifid_r;
  logic       idex_nop;

  modport master (
    output mem_busy, ex_load, ex_rd, id_rn, id_rm, id_rd,
           id_rn_use, id_rm_use, id_rd_use, id_branch_taken,
    input  pc_le, pc_sel_target, ifid_le, ifid_r, idex_nop
  );

  modport slave (
    input  mem_busy, ex_load, ex_rd, id_rn, id_rm, id_rd,
           id_rn_use, id_rm_use, id_rd_use, id_branch_taken,
    output pc_le, pc_sel_target, ifid_le, ifid_r, idex_nop
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequences the IF/ID pipeline register and the PC. Resolves load-use stalls,
// taken-branch wrong-path flushes and data-memory wait freezes with a
// registered FSM; the pipeline controls are Mealy outputs of state + inputs.
// Priority in every state: mem_busy > load-use > branch taken.
//
// Ports:
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   hz           pipe_hazard_ctrl_if.slave (hazard status in, controls out)
//   mem_timeout  sticky flag: mem_busy held for MEM_TIMEOUT consecutive cycles
//   state_o      FSM state (RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3)
//   stall_cnt    cycles with pc_le=0 (saturating)
//   flush_cnt    cycles with ifid_r=1 (saturating)
//
// Configuration macro: HAZ_PERF_CNT_EN
//   defined   -> stall_cnt / flush_cnt are live saturating counters
//   undefined -> both ports are tied to zero and no counter flops exist
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int LU_STALL    = 1,
  parameter int BR_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  pipe_hazard_ctrl_if.slave  hz,
  output logic               mem_timeout,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  // Remaining-cycle counter must hold the larger of the two sequence lengths.
  localparam int REM_MAX = (LU_STALL > BR_BUBBLES) ? LU_STALL : BR_BUBBLES;
  localparam int REM_W   = $clog2(REM_MAX + 1);
  localparam int WD_W    = $clog2(MEM_TIMEOUT + 1);

  localparam logic [REM_W-1:0] REM_ZERO = REM_W'(0);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
  localparam logic [REM_W-1:0] LU_REM   = REM_W'(LU_STALL - 1);
  localparam logic [REM_W-1:0] BR_REM   = REM_W'(BR_BUBBLES - 1);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(MEM_TIMEOUT);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [REM_W-1:0] rem_r;
  logic [REM_W-1:0] rem_nxt_s;
  logic             in_reset_r;
  logic [WD_W-1:0]  wd_cnt_r;
  logic [WD_W-1:0]  wd_nxt_s;
  logic             mem_timeout_r;
  logic             lu_s;

  logic pc_le_s;
  logic pc_sel_target_s;
  logic ifid_le_s;
  logic ifid_r_s;
  logic idex_nop_s;

  // Load-use: EX holds a load whose destination is read by the ID instruction.
  assign lu_s = hz.ex_load &
                ((hz.id_rn_use & (hz.id_rn == hz.ex_rd)) |
                 (hz.id_rm_use & (hz.id_rm == hz.ex_rd)) |
                 (hz.id_rd_use & (hz.id_rd == hz.ex_rd)));

  // Reset-shadow flag: keeps the reset output pattern for the first cycle after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_reset_r <= 1'b1;
    end else begin
      in_reset_r <= 1'b0;
    end
  end

  // FSM state and remaining-cycle register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_RUN;
      rem_r   <= REM_ZERO;
    end else begin
      state_r <= state_nxt_s;
      rem_r   <= rem_nxt_s;
    end
  end

  // Next-state and Mealy pipeline controls.
  always_comb begin
    state_nxt_s     = state_r;
    rem_nxt_s       = rem_r;
    pc_le_s         = 1'b0;
    pc_sel_target_s = 1'b0;
    ifid_le_s       = 1'b0;
    ifid_r_s        = 1'b0;
    idex_nop_s      = 1'b0;

    if (in_reset_r) begin
      state_nxt_s = ST_RUN;
      rem_nxt_s   = REM_ZERO;
    end else if (hz.mem_busy) begin
      // Freeze: every control low, state and remaining count hold.
      if (state_r == ST_RUN) begin
        state_nxt_s = ST_MEM_WAIT;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      case (state_r)
        // MEM_WAIT with memory ready behaves exactly like RUN.
        ST_RUN, ST_MEM_WAIT: begin
          if (lu_s) begin
            idex_nop_s = 1'b1;
            rem_nxt_s  = LU_REM;
            if (LU_REM != REM_ZERO) begin
              state_nxt_s = ST_LU_STALL;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else if (hz.id_branch_taken) begin
            pc_le_s         = 1'b1;
            pc_sel_target_s = 1'b1;
            ifid_le_s       = 1'b1;
            ifid_r_s        = 1'b1;
            rem_nxt_s       = BR_REM;
            if (BR_REM != REM_ZERO) begin
              state_nxt_s = ST_FLUSH;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            pc_le_s     = 1'b1;
            ifid_le_s   = 1'b1;
            state_nxt_s = ST_RUN;
          end
        end
        // Branch requests are ignored until the stall drains.
        ST_LU_STALL: begin
          idex_nop_s = 1'b1;
          rem_nxt_s  = rem_r - REM_ONE;
          if (rem_r == REM_ONE) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_LU_STALL;
          end
        end
        // Wrong-path cleanup: keep fetching sequentially, squash IF/ID and ID/EX.
        ST_FLUSH: begin
          pc_le_s    = 1'b1;
          ifid_r_s   = 1'b1;
          idex_nop_s = 1'b1;
          rem_nxt_s  = rem_r - REM_ONE;
          if (rem_r == REM_ONE) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_FLUSH;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          rem_nxt_s   = REM_ZERO;
        end
      endcase
    end
  end

  // Output stage: the reset pattern overrides the FSM controls.
  always_comb begin
    if (in_reset_r) begin
      hz.pc_le         = 1'b0;
      hz.pc_sel_target = 1'b0;
      hz.ifid_le       = 1'b0;
      hz.ifid_r        = 1'b1;
      hz.idex_nop      = 1'b1;
    end else begin
      hz.pc_le         = pc_le_s;
      hz.pc_sel_target = pc_sel_target_s;
      hz.ifid_le       = ifid_le_s;
      hz.ifid_r        = ifid_r_s;
      hz.idex_nop      = idex_nop_s;
    end
  end

  // Saturating increment of the consecutive-busy watchdog.
  always_comb begin
    if (wd_cnt_r == WD_LIMIT) begin
      wd_nxt_s = wd_cnt_r;
    end else begin
      wd_nxt_s = wd_cnt_r + WD_ONE;
    end
  end

  // Watchdog: counts consecutive busy cycles; the timeout flag is sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_r      <= {WD_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else if (hz.mem_busy && !in_reset_r) begin
      wd_cnt_r <= wd_nxt_s;
      if (wd_nxt_s == WD_LIMIT) begin
        mem_timeout_r <= 1'b1;
      end else begin
        mem_timeout_r <= mem_timeout_r;
      end
    end else begin
      wd_cnt_r      <= {WD_W{1'b0}};
      mem_timeout_r <= mem_timeout_r;
    end
  end

  assign mem_timeout = mem_timeout_r;
  assign state_o     = state_r;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating perf counters; the reset-shadow cycle is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!in_reset_r && !pc_le_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (!in_reset_r && ifid_r_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed testbench for pipe_hazard_ctrl (LU_STALL=2, BR_BUBBLES=2,
// MEM_TIMEOUT=255). Inputs change on the falling edge; outputs are checked
// 1 ns later, well away from the rising edge.
// Control vector order: {pc_le, pc_sel_target, ifid_le, ifid_r, idex_nop}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [4:0] O_RST    = 5'b00011;
  localparam logic [4:0] O_RUN    = 5'b10100;
  localparam logic [4:0] O_STALL  = 5'b00001;
  localparam logic [4:0] O_TAKEN  = 5'b11110;
  localparam logic [4:0] O_FLUSH  = 5'b10011;
  localparam logic [4:0] O_FREEZE = 5'b00000;

  logic             clk;
  logic             reset_n;
  logic             mem_timeout;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [4:0]       outs;

  int total;
  int bad;

  pipe_hazard_ctrl_if hz_if ();

  pipe_hazard_ctrl #(
    .LU_STALL    (2),
    .BR_BUBBLES  (2),
    .MEM_TIMEOUT (255),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hz          (hz_if),
    .mem_timeout (mem_timeout),
    .state_o     (state_o),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  assign outs = {hz_if.pc_le, hz_if.pc_sel_target, hz_if.ifid_le,
                 hz_if.ifid_r, hz_if.idex_nop};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    hz_if.mem_busy        = 1'b0;
    hz_if.ex_load         = 1'b0;
    hz_if.ex_rd           = 4'd0;
    hz_if.id_rn           = 4'd1;
    hz_if.id_rm           = 4'd2;
    hz_if.id_rd           = 4'd3;
    hz_if.id_rn_use       = 1'b0;
    hz_if.id_rm_use       = 1'b0;
    hz_if.id_rd_use       = 1'b0;
    hz_if.id_branch_taken = 1'b0;
  endtask

  task automatic set_lu();
    hz_if.ex_load   = 1'b1;
    hz_if.ex_rd     = 4'd4;
    hz_if.id_rm     = 4'd4;
    hz_if.id_rm_use = 1'b1;
  endtask

  // Advance to the next falling edge with idle inputs.
  task automatic next_idle();
    @(negedge clk);
    idle_in();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    idle_in();
    reset_n = 1'b0;
    #1;
    check_eq({tag, "_rst_out"}, 32'(outs), 32'(O_RST));
    check_eq({tag, "_rst_state"}, 32'(state_o), 32'd0);
    check_eq({tag, "_rst_scnt"}, 32'(stall_cnt), 32'd0);
    check_eq({tag, "_rst_fcnt"}, 32'(flush_cnt), 32'd0);
    check_eq({tag, "_rst_to"}, 32'(mem_timeout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq({tag, "_rel_out"}, 32'(outs), 32'(O_RST));
    next_idle();
    #1;
    check_eq({tag, "_run_out"}, 32'(outs), 32'(O_RUN));
    check_eq({tag, "_run_state"}, 32'(state_o), 32'd0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    idle_in();

    // 1: reset held three cycles, then release
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq("t1_hold_out", 32'(outs), 32'(O_RST));
      check_eq("t1_hold_state", 32'(state_o), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("t1_rel_out", 32'(outs), 32'(O_RST));
    next_idle();
    #1;
    check_eq("t1_run_out", 32'(outs), 32'(O_RUN));
    check_eq("t1_run_state", 32'(state_o), 32'd0);

    // near misses: matching register but not used / not a load
    @(negedge clk);
    idle_in();
    hz_if.ex_load = 1'b1;
    hz_if.ex_rd   = 4'd7;
    hz_if.id_rn   = 4'd7;
    #1;
    check_eq("nolu_unused", 32'(outs), 32'(O_RUN));
    @(negedge clk);
    hz_if.ex_load   = 1'b0;
    hz_if.id_rn_use = 1'b1;
    #1;
    check_eq("nolu_noload", 32'(outs), 32'(O_RUN));
    @(negedge clk);
    hz_if.ex_load   = 1'b1;
    hz_if.id_rn_use = 1'b0;
    hz_if.id_rd     = 4'd7;
    hz_if.id_rd_use = 1'b1;
    #1;
    check_eq("lu_rd_out", 32'(outs), 32'(O_STALL));
    next_idle();
    #1;
    check_eq("lu_rd_stall2", 32'(outs), 32'(O_STALL));
    check_eq("lu_rd_state", 32'(state_o), 32'd1);

    // 2: load-use stall of two cycles
    do_reset("t2");
    @(negedge clk);
    set_lu();
    #1;
    check_eq("t2_c0_out", 32'(outs), 32'(O_STALL));
    check_eq("t2_c0_state", 32'(state_o), 32'd0);
    next_idle();
    #1;
    check_eq("t2_c1_out", 32'(outs), 32'(O_STALL));
    check_eq("t2_c1_state", 32'(state_o), 32'd1);
    check_eq("t2_c1_scnt", 32'(stall_cnt), PERF ? 32'd1 : 32'd0);
    next_idle();
    #1;
    check_eq("t2_c2_out", 32'(outs), 32'(O_RUN));
    check_eq("t2_c2_state", 32'(state_o), 32'd0);
    check_eq("t2_scnt", 32'(stall_cnt), PERF ? 32'd2 : 32'd0);
    check_eq("t2_fcnt", 32'(flush_cnt), 32'd0);

    // 3: taken branch with two flush cycles; taken ignored in FLUSH
    do_reset("t3");
    @(negedge clk);
    hz_if.id_branch_taken = 1'b1;
    #1;
    check_eq("t3_c0_out", 32'(outs), 32'(O_TAKEN));
    check_eq("t3_c0_state", 32'(state_o), 32'd0);
    @(negedge clk);
    #1;
    check_eq("t3_c1_out", 32'(outs), 32'(O_FLUSH));
    check_eq("t3_c1_state", 32'(state_o), 32'd2);
    next_idle();
    #1;
    check_eq("t3_c2_out", 32'(outs), 32'(O_RUN));
    check_eq("t3_c2_state", 32'(state_o), 32'd0);
    check_eq("t3_fcnt", 32'(flush_cnt), PERF ? 32'd2 : 32'd0);
    check_eq("t3_scnt", 32'(stall_cnt), 32'd0);

    // 4: load-use and branch together -> stall first, branch afterwards
    do_reset("t4");
    @(negedge clk);
    set_lu();
    hz_if.id_branch_taken = 1'b1;
    #1;
    check_eq("t4_c0_out", 32'(outs), 32'(O_STALL));
    @(negedge clk);
    idle_in();
    hz_if.id_branch_taken = 1'b1;
    #1;
    check_eq("t4_c1_out", 32'(outs), 32'(O_STALL));
    check_eq("t4_c1_state", 32'(state_o), 32'd1);
    @(negedge clk);
    #1;
    check_eq("t4_c2_out", 32'(outs), 32'(O_TAKEN));
    check_eq("t4_c2_state", 32'(state_o), 32'd0);
    next_idle();
    #1;
    check_eq("t4_c3_out", 32'(outs), 32'(O_FLUSH));
    next_idle();
    #1;
    check_eq("t4_c4_out", 32'(outs), 32'(O_RUN));
    check_eq("t4_scnt", 32'(stall_cnt), PERF ? 32'd2 : 32'd0);
    check_eq("t4_fcnt", 32'(flush_cnt), PERF ? 32'd2 : 32'd0);

    // MEM_WAIT: 254 busy cycles from RUN, one short of the timeout
    do_reset("mw");
    for (int i = 0; i < 254; i++) begin
      @(negedge clk);
      hz_if.mem_busy = 1'b1;
      #1;
      if (i == 0) begin
        check_eq("mw_first_out", 32'(outs), 32'(O_FREEZE));
        check_eq("mw_first_state", 32'(state_o), 32'd0);
      end
      if (i == 253) begin
        check_eq("mw_last_out", 32'(outs), 32'(O_FREEZE));
        check_eq("mw_last_state", 32'(state_o), 32'd3);
        check_eq("mw_last_to", 32'(mem_timeout), 32'd0);
      end
    end
    next_idle();
    #1;
    check_eq("mw_exit_out", 32'(outs), 32'(O_RUN));
    check_eq("mw_exit_state", 32'(state_o), 32'd3);
    check_eq("mw_exit_to", 32'(mem_timeout), 32'd0);
    next_idle();
    #1;
    check_eq("mw_run_state", 32'(state_o), 32'd0);

    // 5: 255 busy cycles in the middle of FLUSH
    do_reset("t5");
    @(negedge clk);
    hz_if.id_branch_taken = 1'b1;
    #1;
    check_eq("t5_taken_out", 32'(outs), 32'(O_TAKEN));
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      idle_in();
      hz_if.mem_busy = 1'b1;
      #1;
      check_eq("t5_frz_out", 32'(outs), 32'(O_FREEZE));
      if (i == 0 || i == 254) begin
        check_eq("t5_frz_state", 32'(state_o), 32'd2);
        check_eq("t5_frz_to", 32'(mem_timeout), 32'd0);
      end
    end
    next_idle();
    #1;
    check_eq("t5_resume_out", 32'(outs), 32'(O_FLUSH));
    check_eq("t5_resume_state", 32'(state_o), 32'd2);
    check_eq("t5_to_set", 32'(mem_timeout), 32'd1);
    next_idle();
    #1;
    check_eq("t5_end_out", 32'(outs), 32'(O_RUN));
    check_eq("t5_end_state", 32'(state_o), 32'd0);
    check_eq("t5_to_sticky", 32'(mem_timeout), 32'd1);
    check_eq("t5_scnt", 32'(stall_cnt), PERF ? 32'd255 : 32'd0);
    check_eq("t5_fcnt", 32'(flush_cnt), PERF ? 32'd2 : 32'd0);

    // 6: asynchronous reset pulse while in LU_STALL
    do_reset("t6");
    @(negedge clk);
    set_lu();
    #1;
    check_eq("t6_c0_out", 32'(outs), 32'(O_STALL));
    next_idle();
    #1;
    check_eq("t6_c1_state", 32'(state_o), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_async_out", 32'(outs), 32'(O_RST));
    check_eq("t6_async_state", 32'(state_o), 32'd0);
    check_eq("t6_async_scnt", 32'(stall_cnt), 32'd0);
    check_eq("t6_async_to", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    next_idle();
    #1;
    check_eq("t6_after_out", 32'(outs), 32'(O_RUN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
